// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: small circular FIFO of (instruction, pc)
// pairs with first-word fall-through and flush on control-flow redirect.
module if_id_queue #(
  parameter int PC_WIDTH          = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DEPTH             = 4,
  parameter int CNT_WIDTH         = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] enq_instruction,
  input  logic [PC_WIDTH-1:0]          enq_pc,
  output logic                         enq_ready,
  input  logic                         deq_ready,
  output logic                         deq_valid,
  output logic [INSTRUCTION_WIDTH-1:0] deq_instruction,
  output logic [PC_WIDTH-1:0]          deq_pc,
  output logic [CNT_WIDTH-1:0]         count
);

  localparam int PTR_W = CNT_WIDTH - 1;

  logic [INSTRUCTION_WIDTH-1:0] r_mem_instr [DEPTH];
  logic [PC_WIDTH-1:0]          r_mem_pc    [DEPTH];
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [CNT_WIDTH-1:0]         r_count;
  logic                         w_enq_fire;
  logic                         w_deq_fire;

  // Ready depends only on registered fill level, so a full queue refuses
  // an enqueue even when decode drains an entry in the same cycle.
  assign enq_ready  = (r_count != CNT_WIDTH'(DEPTH));
  assign deq_valid  = (r_count != '0);
  assign w_enq_fire = enq_valid && enq_ready && !flush;
  assign w_deq_fire = deq_valid && deq_ready && !flush;
  assign count      = r_count;

  assign deq_instruction = deq_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign deq_pc          = deq_valid ? r_mem_pc[r_rd_ptr]    : '0;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem_instr[gi] <= '0;
          r_mem_pc[gi]    <= '0;
        end else if (w_enq_fire && (r_wr_ptr == PTR_W'(gi))) begin
          r_mem_instr[gi] <= enq_instruction;
          r_mem_pc[gi]    <= enq_pc;
        end
      end
    end
  endgenerate

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue; one task per scenario.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic [31:0] enq_instruction;
  logic [31:0] enq_pc;
  logic        enq_ready;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instruction;
  logic [31:0] deq_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_queue #(
    .PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .DEPTH(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_instruction(enq_instruction), .enq_pc(enq_pc),
    .enq_ready(enq_ready), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_instruction(deq_instruction), .deq_pc(deq_pc), .count(count)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1ns later; prints one line per transaction.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b fl=%0b enq=%0b pc_in=%h deq_rdy=%0b | cnt=%0d dv=%0b er=%0b pc=%h ins=%h",
             $time, rst, flush, enq_valid, enq_pc, deq_ready,
             count, deq_valid, enq_ready, deq_pc, deq_instruction);
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
    enq_valid       = 1'b1;
    enq_pc          = pc;
    enq_instruction = ins;
  endtask

  task automatic idle();
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    enq_pc = '0; enq_instruction = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", count); end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid actual=%0b required=0", deq_valid); end
    checks++; if (deq_pc !== 32'h0) begin errors++; $display("FAIL reset_deq_pc actual=%h required=0", deq_pc); end
    checks++; if (deq_instruction !== 32'h0) begin errors++; $display("FAIL reset_deq_ins actual=%h required=0", deq_instruction); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready actual=%0b required=1", enq_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      offer(32'h10 + i, 32'hA000_0001 + i);
      tick();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count actual=%0d required=%0d", count, i + 1); end
      checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL fill_deq_valid actual=%0b required=1", deq_valid); end
      checks++; if (deq_pc !== 32'h10) begin errors++; $display("FAIL fill_head_pc actual=%h required=10", deq_pc); end
      checks++; if (deq_instruction !== 32'hA000_0001) begin errors++; $display("FAIL fill_head_ins actual=%h required=a0000001", deq_instruction); end
    end
    idle();
  endtask

  task automatic test_full_drain();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL pre_flush_count actual=%0d required=0", count); end
    for (int i = 0; i < 4; i++) begin
      offer(32'h10 + i, 32'hB000_0000 + i);
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count actual=%0d required=4", count); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready actual=%0b required=0", enq_ready); end
    offer(32'h20, 32'hB000_0020);
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count actual=%0d required=4", count); end
    idle();
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (deq_pc !== 32'h10 + i) begin errors++; $display("FAIL drain_pc actual=%h required=%h", deq_pc, 32'h10 + i); end
      checks++; if (deq_instruction !== 32'hB000_0000 + i) begin errors++; $display("FAIL drain_ins actual=%h required=%h", deq_instruction, 32'hB000_0000 + i); end
      tick();
    end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid actual=%0b required=0", deq_valid); end
    checks++; if (deq_pc !== 32'h0) begin errors++; $display("FAIL drain_empty_pc actual=%h required=0", deq_pc); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_empty_count actual=%0d required=0", count); end
    idle();
  endtask

  task automatic test_back_to_back();
    deq_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      offer(32'(k), 32'hC000_0000 + k);
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count actual=%0d required=1", count); end
      checks++; if (deq_pc !== 32'(k)) begin errors++; $display("FAIL b2b_pc actual=%h required=%h", deq_pc, k); end
    end
    enq_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_final_count actual=%0d required=0", count); end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      offer(32'h30 + i, 32'hD000_0000 + i);
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL preflush_count actual=%0d required=3", count); end
    offer(32'h40, 32'hD000_0040);
    deq_ready = 1'b1;
    flush     = 1'b1;
    tick();
    idle();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count actual=%0d required=0", count); end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL flush_deq_valid actual=%0b required=0", deq_valid); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_enq_ready actual=%0b required=1", enq_ready); end
    checks++; if (deq_pc !== 32'h0) begin errors++; $display("FAIL flush_deq_pc actual=%h required=0", deq_pc); end
    offer(32'h50, 32'hD000_0050);
    tick();
    idle();
    checks++; if (deq_pc !== 32'h50) begin errors++; $display("FAIL postflush_pc actual=%h required=50", deq_pc); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL postflush_count actual=%0d required=1", count); end
    deq_ready = 1'b1;
    tick();
    idle();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL postflush_drain actual=%0d required=0", count); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) begin
      offer(32'h60 + i, 32'hE000_0000 + i);
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL simul_full_count actual=%0d required=4", count); end
    offer(32'h70, 32'hE000_0070);
    deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL simul_count actual=%0d required=3", count); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (deq_pc !== 32'h60 + i) begin errors++; $display("FAIL simul_drain_pc actual=%h required=%h", deq_pc, 32'h60 + i); end
      tick();
    end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL simul_empty actual=%0b required=0 (pc=%h)", deq_valid, deq_pc); end
    idle();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2; i++) begin
      offer(32'h80 + i, 32'hF000_0000 + i);
      tick();
    end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL prerst_count actual=%0d required=2", count); end
    offer(32'h90, 32'hF000_0090);
    deq_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count actual=%0d required=0", count); end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL midrst_deq_valid actual=%0b required=0", deq_valid); end
    checks++; if (deq_instruction !== 32'h0) begin errors++; $display("FAIL midrst_deq_ins actual=%h required=0", deq_instruction); end
    checks++; if (deq_pc !== 32'h0) begin errors++; $display("FAIL midrst_deq_pc actual=%h required=0", deq_pc); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL midrst_enq_ready actual=%0b required=1", enq_ready); end
    offer(32'hA0, 32'hF000_00A0);
    tick();
    idle();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL resume_count actual=%0d required=1", count); end
    checks++; if (deq_pc !== 32'hA0) begin errors++; $display("FAIL resume_pc actual=%h required=a0", deq_pc); end
    checks++; if (deq_instruction !== 32'hF000_00A0) begin errors++; $display("FAIL resume_ins actual=%h required=f00000a0", deq_instruction); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_full_drain();
    test_back_to_back();
    test_flush();
    test_full_simul();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction fetch queue between the fetch stage and the decode stage.
- Buffers fetched (instruction, pc) pairs in a small circular FIFO so that fetch can run ahead while decode is stalled.
- Presents the oldest entry to decode through a valid/ready handshake.
- Discards all buffered entries on a control-flow redirect (jump or taken branch).

Parameters:
- PC_WIDTH, 32, width of a program-counter value.
- INSTRUCTION_WIDTH, 32, width of one instruction word.
- DEPTH, 4, number of entries. Must be a power of two, at least 2.
- CNT_WIDTH, 3, width of the fill counter. Must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  redirect from jump/branch; empties the queue.
- enq_valid  input  1  fetch offers an entry this cycle.
- enq_instruction  input  INSTRUCTION_WIDTH  fetched instruction.
- enq_pc  input  PC_WIDTH  pc of the fetched instruction.
- enq_ready  output  1  queue can accept an entry (not full).
- deq_ready  input  1  decode consumes the head entry this cycle.
- deq_valid  output  1  head entry is valid (not empty).
- deq_instruction  output  INSTRUCTION_WIDTH  head instruction; 0 when empty.
- deq_pc  output  PC_WIDTH  head pc; 0 when empty.
- count  output  CNT_WIDTH  number of valid entries, 0..DEPTH.

Behaviour:
- Reset:
  - Synchronous: sampled only on a rising clk edge.
  - Clears rd_ptr, wr_ptr, count and all storage to 0.
  - After reset: deq_valid=0, deq_instruction=0, deq_pc=0, enq_ready=1, count=0.
  - Reset asserted mid-operation discards all entries and overrides flush, enq and deq in the same cycle.
- Handshakes:
  - Enqueue fires when enq_valid && enq_ready && !flush. It writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
  - Dequeue fires when deq_valid && deq_ready && !flush. It increments rd_ptr modulo DEPTH.
  - Ready signals are ignored when the corresponding valid is 0. Dequeue while empty has no effect.
- Outputs:
  - enq_ready = (count != DEPTH), purely from registered state. No combinational path from deq_ready to enq_ready.
  - When full, an enqueue is refused even if a dequeue fires in the same cycle.
  - deq_valid = (count != 0). deq_instruction and deq_pc are taken combinationally from mem[rd_ptr] when deq_valid=1, else 0 (0 decodes as NOP).
- Latency:
  - An entry enqueued at edge N is visible on the deq_* outputs after edge N (first-word fall-through from storage).
  - There is no same-cycle bypass from enq_* to deq_*.
- Count update:
  - +1 on enqueue only; -1 on dequeue only.
  - Unchanged when both fire or when neither fires.
  - Pointers wrap from DEPTH-1 to 0.
- Simultaneous enqueue and dequeue on a non-empty, non-full queue: both fire, count is unchanged, and order is preserved.
- Flush:
  - At the next edge: rd_ptr=wr_ptr=0 and count=0.
  - The enqueue and dequeue offered in the flush cycle are both dropped.
  - Storage contents need not be cleared, but outputs read 0 because deq_valid=0.
  - Flush on an empty queue is a no-op apart from resetting the pointers.
- Ordering: strict FIFO. deq_pc values leave in the same order they were enqueued.
- No overflow or underflow is ever possible; count never exceeds DEPTH.

Test Plan:
1. Reset, then enqueue pc 0x10/0x11/0x12 with instructions 0xA0000001/02/03 and deq_ready=0.
   - count goes 1, 2, 3; deq_valid=1; deq_pc=0x10 throughout.
2. Enqueue 4 entries with deq_ready=0.
   - count=4 and enq_ready=0. A 5th offer (pc 0x20) is not stored.
   - Then deq_ready=1 for 4 cycles: deq_pc sequence 0x10, 0x11, 0x12, 0x13, then deq_valid=0 and deq_pc=0.
3. Hold enq_valid=1 and deq_ready=1 continuously with pcs 0x0..0x9.
   - After the first edge, count stays 1.
   - Pointers wrap past 3 and deq_pc follows 0x0..0x9 in order, one cycle behind enqueue.
4. Fill to 3 entries, then assert flush together with enq_valid (pc 0x40) and deq_ready.
   - Next cycle: count=0, deq_valid=0, enq_ready=1.
   - pc 0x40 is absent. The next enqueue of pc 0x50 appears at the head.
5. Queue full (count=4), enq_valid=1, deq_ready=1.
   - Only the dequeue fires: count becomes 3 and the offered entry is not stored.
6. Assert rst with 2 entries buffered and enq_valid=1.
   - After the edge: count=0, deq_valid=0, deq_instruction=0, deq_pc=0, enq_ready=1.
   - After rst deasserts, normal operation resumes.
